can_crc_checker: RTL and testbench
==================================

# can_crc_checker

Receive-side CRC-15 checker for the CAN controller, the counterpart to the transmit CRC generator. Consumes the destuffed serial bit stream from the bit-timing/destuff stage starting at SOF. Accumulates the CRC over the frame's covered bits, then captures the 15-bit received CRC field and checks the CRC delimiter. Reports crc_ok / crc_err / form_err to the RX frame FSM.

## Interface
- POLY, 15'h4599, CRC-15 CAN generator polynomial (x^15 term implicit)
- INIT, 15'h0000, CRC register value loaded at SOF
- LEN_W, 7, width of frame_len (max covered length 83 bits)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- bit_in  input  1  destuffed bus bit (0 = dominant)
- bit_valid  input  1  bit_in is a new sample this cycle (one pulse per bit time)
- sof  input  1  qualifies the current bit_valid bit as SOF (first covered bit); sampled only with bit_valid
- frame_len  input  LEN_W  number of CRC-covered bits, SOF inclusive; sampled on sof & bit_valid
- abort  input  1  RX FSM error/arbitration abort; returns block to IDLE
- busy  output  1  high in any state other than IDLE
- crc_calc  output  15  computed CRC; frozen after last covered bit until next SOF
- crc_rx  output  15  received CRC field, MSB first
- crc_ok  output  1  one-cycle pulse: crc_rx == crc_calc and delimiter recessive
- crc_err  output  1  one-cycle pulse: crc_rx != crc_calc (delimiter recessive)
- form_err  output  1  one-cycle pulse: delimiter dominant (overrides crc_ok/crc_err)

## Operation
- States: IDLE, ACCUM, FIELD, DELIM.
- IDLE: on bit_valid & sof, load crc = INIT, rem = frame_len, and process the bit per the ACCUM rule. Next state is ACCUM, or FIELD if frame_len is 1. frame_len == 0: do not process the bit; go to FIELD with crc_calc = INIT.
- ACCUM, per valid bit: nxt = bit_in ^ crc[14]; crc = {crc[13:0],1'b0} ^ (nxt ? POLY : 0); rem decrements. Go to FIELD after the bit that takes rem to 0.
- FIELD: shift bit_in into crc_rx LSB (crc_rx = {crc_rx[13:0], bit_in}); 4-bit counter. Go to DELIM after the 15th bit.
- DELIM: on the next valid bit, evaluate and pulse exactly one result, then return to IDLE.
  - bit_in == 0: form_err.
  - else if crc_rx == crc_calc: crc_ok.
  - else: crc_err.
- Bits with bit_valid low are ignored in every state; sof is ignored unless bit_valid is high.
- sof & bit_valid outside IDLE: hard resync. Restart as from IDLE with no result pulse.
- abort in any state: go to IDLE next cycle, no result pulse. abort with sof in the same cycle: abort wins.
- crc_calc and crc_rx are not cleared on abort; they hold until the next SOF. At SOF, crc_rx clears to 0.

## Timing
- Reset (rst == 0 at a clock edge): state IDLE, busy 0, crc_calc 0, crc_rx 0, result pulses 0, counters 0. Reset mid-frame discards the frame silently.
- All outputs are registered. A result pulse is asserted in the cycle after the clock edge that samples the delimiter bit, and lasts 1 cycle.
- busy rises the cycle after SOF is sampled. It falls in the same cycle the result pulse is asserted.
- Back-to-back: a valid SOF bit in the cycle the result pulse is high is accepted, because the block is already in IDLE.
- Throughput: one bit per cycle supported (bit_valid held high).

## Configuration
- CAN_CRC_ERRCNT_EN defined: adds output err_cnt [7:0], a saturating counter (stops at 255).
  - Increments once per crc_err or form_err pulse.
  - Resets to 0 on rst only; abort does not clear it.
- Not defined: port absent, no counter logic.

## Structure
- Shared package can_pkg:
  - CRC15_POLY (15'h4599).
  - CRC field length constant (15).
  - Checker state enum typedef (IDLE/ACCUM/FIELD/DELIM).
- One sub-module: can_crc15_step, a combinational single-bit CRC update (crc_in, bit) -> crc_out, parameterised by POLY. The transmit side can reuse it.

## Test plan
- frame_len=1, bit 0; field 15'h0000; delimiter 1 -> crc_calc=15'h0000, crc_ok pulse, busy low same cycle.
- frame_len=1, bit 1; field 15'h4599; delimiter 1 -> crc_calc=15'h4599, crc_ok.
- frame_len=2, bits 1,0; field 15'h4EAB with bit 0 flipped (15'h4EAA) -> crc_err; err_cnt=1 with CAN_CRC_ERRCNT_EN.
- frame_len=1, bit 1; field 15'h4599; delimiter 0 -> form_err only, no crc_ok.
- frame_len=2, bits 1,0 with bit_valid gapped 3 idle cycles between bits; field 15'h4EAB -> crc_ok. A repeat with abort during FIELD -> no pulse, busy low next cycle.
- sof during FIELD of frame A, then a valid 1-bit frame B (bit 1, field 15'h4599) -> single crc_ok for B only; rst=0 mid-ACCUM -> all outputs 0.

Source files
------------

// File: rtl/can_pkg.sv
// CAN shared definitions: CRC-15 polynomial, CRC field length, checker state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package can_pkg;

    localparam logic [14:0] CRC15_POLY = 15'h4599;
    localparam int          CRC15_LEN  = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIELD = 2'd2,
        DELIM = 2'd3
    } crc_chk_state_t;

endpackage

// File: rtl/can_crc15_step.sv
// Single-bit CRC-15 update (x^15 term implicit); shared by the TX generator and RX checker.
// Latency: combinational.
// Backpressure: none.
module can_crc15_step
    import can_pkg::*;
#(
    parameter logic [14:0] POLY = CRC15_POLY
) (
    input  logic [14:0] crc_in,
    input  logic        bit_in,
    output logic [14:0] crc_out
);

    logic nxt;

    assign nxt     = bit_in ^ crc_in[14];
    assign crc_out = {crc_in[13:0], 1'b0} ^ (nxt ? POLY : 15'h0000);

endmodule

// File: rtl/can_crc_checker.sv
// RX CRC-15 checker: accumulates CRC from SOF, captures the CRC field, checks the delimiter.
// Latency: result pulse one cycle after the delimiter bit is sampled; one bit per cycle max.
// Backpressure: none, bit_valid is a strobe; abort/sof resynchronise. Option CAN_CRC_ERRCNT_EN adds err_cnt.
module can_crc_checker
    import can_pkg::*;
#(
    parameter logic [14:0] POLY  = CRC15_POLY,
    parameter logic [14:0] INIT  = 15'h0000,
    parameter int          LEN_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             sof,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             abort,
    output logic             busy,
    output logic [14:0]      crc_calc,
    output logic [14:0]      crc_rx,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             form_err
`ifdef CAN_CRC_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    crc_chk_state_t   state;
    logic [LEN_W-1:0] rem;
    logic [3:0]       fcnt;
    logic             start;
    logic             fld_last;
    logic [14:0]      step_in;
    logic [14:0]      step_out;

    // A qualified SOF restarts from INIT regardless of the current state.
    assign start    = bit_valid & sof;
    assign step_in  = start ? INIT : crc_calc;
    assign fld_last = (fcnt == 4'(CRC15_LEN - 1));

    can_crc15_step #(.POLY(POLY)) u_step (
        .crc_in  (step_in),
        .bit_in  (bit_in),
        .crc_out (step_out)
    );

    // Frame sequencing: abort beats SOF, SOF beats normal progress; results are one-cycle pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rem      <= '0;
            fcnt     <= '0;
            crc_calc <= '0;
            crc_rx   <= '0;
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            form_err <= 1'b0;
        end else begin
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            form_err <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (start) begin
                crc_rx <= '0;
                fcnt   <= '0;
                busy   <= 1'b1;
                if (frame_len == '0) begin
                    // Nothing covered: the SOF bit itself is not folded into the CRC.
                    crc_calc <= INIT;
                    rem      <= '0;
                    state    <= FIELD;
                end else begin
                    crc_calc <= step_out;
                    rem      <= frame_len - LEN_W'(1);
                    state    <= (frame_len == LEN_W'(1)) ? FIELD : ACCUM;
                end
            end else if (bit_valid) begin
                case (state)
                    ACCUM: begin
                        crc_calc <= step_out;
                        rem      <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) begin
                            state <= FIELD;
                        end
                    end
                    FIELD: begin
                        crc_rx <= {crc_rx[13:0], bit_in};
                        if (fld_last) begin
                            fcnt  <= '0;
                            state <= DELIM;
                        end else begin
                            fcnt <= fcnt + 4'd1;
                        end
                    end
                    DELIM: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!bit_in) begin
                            form_err <= 1'b1;
                        end else if (crc_rx == crc_calc) begin
                            crc_ok <= 1'b1;
                        end else begin
                            crc_err <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef CAN_CRC_ERRCNT_EN
    logic delim_err;

    // Same qualification as the DELIM branch above, minus the crc_ok outcome.
    assign delim_err = bit_valid & ~abort & ~start & (state == DELIM) &
                       (~bit_in | (crc_rx != crc_calc));

    // Saturating error counter; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (delim_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_can_crc_checker.sv
// Scoreboard bench for can_crc_checker: stimulus pushes expected results, a monitor pops on each pulse.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_can_crc_checker;

    localparam logic [14:0] POLY = 15'h4599;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        sof = 1'b0;
    logic [6:0]  frame_len = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic [14:0] crc_calc;
    logic [14:0] crc_rx;
    logic        crc_ok;
    logic        crc_err;
    logic        form_err;
`ifdef CAN_CRC_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    can_crc_checker dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .sof       (sof),
        .frame_len (frame_len),
        .abort     (abort),
        .busy      (busy),
        .crc_calc  (crc_calc),
        .crc_rx    (crc_rx),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .form_err  (form_err)
`ifdef CAN_CRC_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 ok, 1 crc error, 2 form error
        logic [14:0] calc;
        logic [14:0] rx;
        int          ecnt;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_errs = 0;
    logic [0:127] msg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference CRC: remainder of M(x)*x^15 divided by G(x), by long division on a bit array.
    function automatic logic [14:0] ref_crc(input int len);
        bit          r[0:127];
        logic [15:0] g;
        logic [14:0] res;
        g = {1'b1, POLY};
        for (int i = 0; i < 128; i++) r[i] = 1'b0;
        for (int i = 0; i < len; i++) r[i] = msg[i];
        for (int i = 0; i < len; i++) begin
            if (r[i]) begin
                for (int j = 0; j < 16; j++) r[i+j] = r[i+j] ^ g[15-j];
            end
        end
        for (int j = 0; j < 15; j++) res[14-j] = r[len+j];
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s, input int flen, input int gap);
        bit_in    = b;
        sof       = s;
        frame_len = 7'(flen);
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        sof       = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic run_frame(input int len, input logic [14:0] field, input logic delim, input int gap);
        exp_t e;
        e.calc = ref_crc(len);
        e.rx   = field;
        e.kind = !delim ? 2 : ((field == e.calc) ? 0 : 1);
        if (e.kind != 0 && exp_errs < 255) exp_errs++;
        e.ecnt = exp_errs;
        if (len == 0) send_bit(1'($urandom_range(0, 1)), 1'b1, 0, gap);
        else for (int i = 0; i < len; i++) send_bit(msg[i], (i == 0), len, gap);
        for (int i = 0; i < 15; i++) send_bit(field[14-i], 1'b0, 0, gap);
        sb.push_back(e);
        send_bit(delim, 1'b0, 0, gap);
    endtask

    exp_t mon_e;
    int   mon_k;

    // Monitor: every result pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && (crc_ok || crc_err || form_err)) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: got ok=%0b err=%0b form=%0b, expected no pulse at %0t",
                         crc_ok, crc_err, form_err, $time);
            end else begin
                mon_e = sb.pop_front();
                mon_k = crc_ok ? 0 : (crc_err ? 1 : 2);
                chk("result_kind", 32'(mon_k), 32'(mon_e.kind));
                chk("pulse_onehot", 32'(crc_ok) + 32'(crc_err) + 32'(form_err), 32'd1);
                chk("crc_calc", 32'(crc_calc), 32'(mon_e.calc));
                chk("crc_rx", 32'(crc_rx), 32'(mon_e.rx));
                chk("busy_at_pulse", 32'(busy), 32'd0);
`ifdef CAN_CRC_ERRCNT_EN
                chk("err_cnt", 32'(err_cnt), 32'(mon_e.ecnt));
`endif
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_crc_calc"}, 32'(crc_calc), 32'd0);
        chk({tag, "_crc_rx"}, 32'(crc_rx), 32'd0);
        chk({tag, "_pulses"}, {29'd0, crc_ok, crc_err, form_err}, 32'd0);
`ifdef CAN_CRC_ERRCNT_EN
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
`endif
    endtask

    initial begin
        logic [14:0] c;
        int          len;
        logic [14:0] field;
        repeat (3) tick();
        chk_reset_state("reset");
        rst = 1'b1;
        tick();

        // Single covered dominant bit, all-zero CRC.
        msg[0] = 1'b0;
        run_frame(1, 15'h0000, 1'b1, 0);
        // Single recessive bit gives the polynomial itself.
        msg[0] = 1'b1;
        run_frame(1, 15'h4599, 1'b1, 0);
        // Two bits, corrupted CRC field.
        msg[0] = 1'b1; msg[1] = 1'b0;
        run_frame(2, 15'h4EAA, 1'b1, 0);
        // Dominant delimiter.
        msg[0] = 1'b1;
        run_frame(1, 15'h4599, 1'b0, 0);
        // Gapped bits.
        msg[0] = 1'b1; msg[1] = 1'b0;
        run_frame(2, 15'h4EAB, 1'b1, 3);

        // Abort during FIELD: no pulse, busy low next cycle, crc_calc held.
        send_bit(1'b1, 1'b1, 2, 3);
        send_bit(1'b0, 1'b0, 0, 3);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 0, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_crc_hold", 32'(crc_calc), 32'h4EAB);
        // Abort together with SOF: abort wins.
        abort = 1'b1;
        send_bit(1'b1, 1'b1, 5, 0);
        abort = 1'b0;
        chk("abort_sof_busy", 32'(busy), 32'd0);
        repeat (3) tick();

        // SOF during FIELD of frame A, then a clean 1-bit frame B.
        send_bit(1'b0, 1'b1, 1, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 0, 0);
        msg[0] = 1'b1;
        run_frame(1, 15'h4599, 1'b1, 0);

        // Reset mid-ACCUM discards the frame.
        for (int i = 0; i < 3; i++) send_bit(1'b1, (i == 0), 10, 0);
        chk("accum_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        tick();
        chk_reset_state("midreset");
        rst = 1'b1;
        exp_errs = 0;
        tick();

        // Randomised frames, including zero-length and back-to-back (gap 0).
        repeat (40) begin
            len = $urandom_range(0, 83);
            for (int i = 0; i < 128; i++) msg[i] = 1'($urandom_range(0, 1));
            c = ref_crc(len);
            field = ($urandom_range(0, 1) == 1) ? c : (c ^ (15'h1 << $urandom_range(0, 14)));
            run_frame(len, field, ($urandom_range(0, 7) != 0), $urandom_range(0, 2));
        end

        repeat (10) tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
